// File: rtl/pair_packer_pkg.sv
// Shared constants and types for the pair_packer block.
// Optional parity storage/output is enabled by defining PAIR_PACKER_PARITY_EN.
package pair_packer_pkg;
  localparam int DEPTH   = 4;
  localparam int SAMPLES = 4;
  localparam int WORD_W  = 2 * SAMPLES;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  typedef logic [WORD_W-1:0] word_t;

  // Counter width that stays legal even for a single-sample word.
  function automatic int cnt_width(input int samples);
    return (samples <= 1) ? 1 : $clog2(samples);
  endfunction
endpackage

// File: rtl/pair_fifo.sv
// Word FIFO for pair_packer: storage, wrapping pointers, explicit level counter.
// With PAIR_PACKER_PARITY_EN defined a parity bit is stored alongside each word.
module pair_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WORD_W-1:0]        i_data,
`ifdef PAIR_PACKER_PARITY_EN
  input  logic                     i_parity,
  output logic                     o_parity,
`endif
  input  logic                     i_pop,
  output logic [WORD_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  import pair_packer_pkg::*;

  localparam int P_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [P_W-1:0]    r_wr_ptr;
  logic [P_W-1:0]    r_rd_ptr;
  logic [P_W:0]      r_level;
  logic              w_full;
  logic              w_empty;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_full    = (r_level == (P_W+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A pop frees the slot the push needs, so a full FIFO still accepts then.
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Empty entries read as zero so stale or uninitialised storage never shows.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_level = r_level;

`ifdef PAIR_PACKER_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_par[r_wr_ptr] <= i_parity;
  end

  assign o_parity = w_empty ? 1'b0 : r_par[r_rd_ptr];
`endif
endmodule

// File: rtl/pair_packer.sv
// Packs {f1,f2} sample pairs into words and queues them in pair_fifo.
// Define PAIR_PACKER_PARITY_EN to add the per-word out_parity output.
module pair_packer #(
  parameter int DEPTH   = pair_packer_pkg::DEPTH,
  parameter int SAMPLES = pair_packer_pkg::SAMPLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f1,
  input  logic                     f2,
  input  logic                     in_en,
  output logic [2*SAMPLES-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
`ifdef PAIR_PACKER_PARITY_EN
  output logic                     out_parity,
`endif
  output logic                     overflow
);
  import pair_packer_pkg::*;

  localparam int W_W   = 2 * SAMPLES;
  localparam int CNT_W = cnt_width(SAMPLES);

  logic [CNT_W-1:0] r_cnt;
  logic [W_W-1:0]   r_word;
  logic             r_overflow;
  logic [W_W-1:0]   w_word;
  logic             w_last;
  logic             w_full;
  logic             w_valid;

  assign w_last = in_en && (r_cnt == CNT_W'(SAMPLES - 1));

  // Assembled word includes the sample being captured this edge.
  generate
    for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_lane
      assign w_word[2*gi+1:2*gi] = (in_en && (r_cnt == CNT_W'(gi))) ?
                                   {f1, f2} : r_word[2*gi+1:2*gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_last) begin
        r_cnt  <= '0;
        r_word <= '0;
      end else if (in_en) begin
        r_cnt  <= r_cnt + 1'b1;
        r_word <= w_word;
      end
      if (w_last && w_full && !(out_ready && w_valid)) r_overflow <= 1'b1;
    end
  end

  pair_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (W_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_last),
    .i_data   (w_word),
`ifdef PAIR_PACKER_PARITY_EN
    .i_parity (^w_word),
    .o_parity (out_parity),
`endif
    .i_pop    (out_ready),
    .o_data   (out_data),
    .o_valid  (w_valid),
    .o_full   (w_full),
    .o_level  (level)
  );

  assign out_valid = w_valid;
  assign full      = w_full;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_pair_packer.sv
// Directed bench for pair_packer with a queue scoreboard of expected words.
// Parity checks are compiled in when PAIR_PACKER_PARITY_EN is defined.
module tb_pair_packer;
  import pair_packer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f1, f2, in_en, out_ready;
  logic [WORD_W-1:0] out_data;
  logic             out_valid, full, overflow;
  logic [LVL_W-1:0] level;
`ifdef PAIR_PACKER_PARITY_EN
  logic             out_parity;
`endif

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  pair_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f1        (f1),
    .f2        (f2),
    .in_en     (in_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .level     (level),
`ifdef PAIR_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, score any pop happening on this edge, step past the edge.
  task automatic cyc(input logic a, input logic b, input logic en, input logic rdy);
    f1 = a; f2 = b; in_en = en; out_ready = rdy;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        $display("pop data=%h expected=%h", out_data, exp_q[0]);
        chk("sb_head", 32'(out_data), 32'(exp_q[0]));
`ifdef PAIR_PACKER_PARITY_EN
        chk("sb_parity", 32'(out_parity), 32'(^exp_q[0]));
`endif
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pack(input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] s3);
    cyc(s0[1], s0[0], 1'b1, 1'b0);
    cyc(s1[1], s1[0], 1'b1, 1'b0);
    cyc(s2[1], s2[0], 1'b1, 1'b0);
    cyc(s3[1], s3[0], 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int edges);
    rst_n = 1'b0; in_en = 1'b0; out_ready = 1'b0; f1 = 1'b0; f2 = 1'b0;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    do_reset(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // First word: 10,01,11,00 -> 8'h36, visible right after the completing edge.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("w1_not_yet_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'h36);
    chk("w1_valid", 32'(out_valid), 32'd1);
    chk("w1_data", 32'(out_data), 32'h36);
    chk("w1_level", 32'(level), 32'd1);

    // Fill to DEPTH with out_ready low.
    pack(2'b01, 2'b01, 2'b01, 2'b01); exp_q.push_back(8'h55);
    pack(2'b11, 2'b11, 2'b00, 2'b00); exp_q.push_back(8'h0F);
    pack(2'b00, 2'b00, 2'b10, 2'b10); exp_q.push_back(8'hA0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_head", 32'(out_data), 32'h36);
    chk("fill_overflow", 32'(overflow), 32'd0);

    // Completing edge coincides with a pop while full.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h99);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_head", 32'(out_data), 32'h55);

    // Fifth word with no pop is dropped.
    pack(2'b11, 2'b11, 2'b11, 2'b11);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_head", 32'(out_data), 32'h55);

    // Held head while out_ready is low.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_head", 32'(out_data), 32'h55);

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("empty_pop_level", 32'(level), 32'd0);

    // Reset mid-word discards partial samples.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    pack(2'b11, 2'b11, 2'b11, 2'b11);
    exp_q.push_back(8'hFF);
    chk("mid_rst_word", 32'(out_data), 32'hFF);
    chk("mid_rst_word_level", 32'(level), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Gapped strobe with out_ready held high on an empty FIFO.
    for (int e = 0; e < 7; e++) begin
      cyc(1'b1, 1'b0, (e % 2) == 0, 1'b1);
      if (e < 6) chk("gap_level", 32'(level), 32'd0);
    end
    exp_q.push_back(8'hAA);
    chk("gap_word", 32'(out_data), 32'hAA);
    chk("gap_word_level", 32'(level), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_pop_level", 32'(level), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_empty_level", 32'(level), 32'd0);

`ifdef PAIR_PACKER_PARITY_EN
    pack(2'b11, 2'b01, 2'b00, 2'b00); exp_q.push_back(8'h07);
    pack(2'b11, 2'b00, 2'b00, 2'b00); exp_q.push_back(8'h03);
    chk("par_07", 32'(out_parity), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_03", 32'(out_parity), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
